// File: rtl/opamp_pkg.sv
// Shared fixed-point types and constants for the opamp comparator slice.
// Q1.15 helpers used by the comparator and its users.
`timescale 1ns/1ps
package opamp_pkg;

    typedef logic signed [15:0] q15_t;

    localparam q15_t Q15_ONE       = 16'sh7FFF;
    localparam q15_t Q15_MINUS_ONE = 16'sh8000;

endpackage

// File: rtl/opamp_hyst_reg.sv
// Hysteresis band compare, decision state flop and registered rise/fall pulses.
// Band edges are held two bits wider than the sample so they cannot wrap.
`timescale 1ns/1ps
module opamp_hyst_reg
    import opamp_pkg::*;
#(
    parameter int WIDTH  = 16,
    parameter int THRESH = 0,
    parameter int HYST   = 0
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic signed [WIDTH-1:0] in,
    output logic                    out_q,
    output logic                    rise,
    output logic                    fall
);

    localparam int EW = WIDTH + 2;
    // An edge outside the sample range is simply never reached.
    localparam logic signed [EW-1:0] HI_EDGE = EW'(THRESH + HYST);
    localparam logic signed [EW-1:0] LO_EDGE = EW'(THRESH - HYST);

    logic signed [EW-1:0] in_ext_s;
    logic                 set_s;
    logic                 clr_s;
    logic                 next_s;
    logic                 out_q_r;
    logic                 rise_r;
    logic                 fall_r;

    assign in_ext_s = {{2{in[WIDTH-1]}}, in};
    assign set_s    = (in_ext_s >= HI_EDGE);
    assign clr_s    = (in_ext_s <  LO_EDGE);

    // Next decision: set above the upper edge, clear below the lower edge, else hold.
    always_comb begin
        next_s = out_q_r;
        if (set_s) begin
            next_s = 1'b1;
        end else if (clr_s) begin
            next_s = 1'b0;
        end else begin
            next_s = out_q_r;
        end
    end

    // Decision flop with edge pulses registered alongside so they coincide with the change.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_q_r <= 1'b0;
            rise_r  <= 1'b0;
            fall_r  <= 1'b0;
        end else begin
            out_q_r <= next_s;
            rise_r  <= next_s & ~out_q_r;
            fall_r  <= ~next_s & out_q_r;
        end
    end

    assign out_q = out_q_r;
    assign rise  = rise_r;
    assign fall  = fall_r;

endmodule

// File: rtl/opamp.sv
// Digital op-amp comparator: zero-latency threshold decision plus a clocked,
// hysteresis-filtered decision with rise/fall event pulses.
`timescale 1ns/1ps
module opamp
    import opamp_pkg::*;
#(
    parameter int WIDTH  = 16,
    parameter int THRESH = 0,
    parameter int HYST   = 0
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic signed [WIDTH-1:0] in,
    output logic                    out,
    output logic                    out_q,
    output logic                    rise,
    output logic                    fall
);

    localparam int EW = WIDTH + 2;
    localparam logic signed [EW-1:0] THR_EXT = EW'(THRESH);

    logic signed [EW-1:0] in_ext_s;

    // The direct decision bypasses all state so it tracks the sample even in reset.
    assign in_ext_s = {{2{in[WIDTH-1]}}, in};
    assign out      = (in_ext_s >= THR_EXT);

    opamp_hyst_reg #(
        .WIDTH  (WIDTH),
        .THRESH (THRESH),
        .HYST   (HYST)
    ) u_hyst (
        .clk   (clk),
        .rst_n (rst_n),
        .in    (in),
        .out_q (out_q),
        .rise  (rise),
        .fall  (fall)
    );

endmodule

// File: tb/tb_opamp.sv
// Self-checking bench for opamp: three parameterisations against an integer
// reference model, plus directed literal expectations.
`timescale 1ns/1ps
module tb_opamp;
    import opamp_pkg::*;

    logic              clk;
    logic              rst_n;
    logic signed [15:0] din [3];
    logic              dout [3];
    logic              dq [3];
    logic              drise [3];
    logic              dfall [3];

    int thr [3] = '{0, 0, 32767};
    int hy  [3] = '{0, 64, 10};

    int n_tests = 0;
    int n_fail  = 0;

    bit mq [3];
    bit mr [3];
    bit mf [3];

    opamp #(.WIDTH(16), .THRESH(0), .HYST(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .in(din[0]),
        .out(dout[0]), .out_q(dq[0]), .rise(drise[0]), .fall(dfall[0]));

    opamp #(.WIDTH(16), .THRESH(0), .HYST(64)) dut1 (
        .clk(clk), .rst_n(rst_n), .in(din[1]),
        .out(dout[1]), .out_q(dq[1]), .rise(drise[1]), .fall(dfall[1]));

    opamp #(.WIDTH(16), .THRESH(32767), .HYST(10)) dut2 (
        .clk(clk), .rst_n(rst_n), .in(din[2]),
        .out(dout[2]), .out_q(dq[2]), .rise(drise[2]), .fall(dfall[2]));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic act, input logic exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    // Decision rule written with plain integer arithmetic on the band edges.
    function automatic bit next_q(input int v, input int t, input int h, input bit q);
        if (v >= t + h) return 1'b1;
        if (v < t - h)  return 1'b0;
        return q;
    endfunction

    // Reference model of the registered decision and its pulses.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < 3; k++) begin
                mq[k] <= 1'b0;
                mr[k] <= 1'b0;
                mf[k] <= 1'b0;
            end
        end else begin
            for (int k = 0; k < 3; k++) begin
                mq[k] <= next_q(int'(din[k]), thr[k], hy[k], mq[k]);
                mr[k] <= next_q(int'(din[k]), thr[k], hy[k], mq[k]) & ~mq[k];
                mf[k] <= ~next_q(int'(din[k]), thr[k], hy[k], mq[k]) & mq[k];
            end
        end
    end

    // Every-cycle compare of all instances against the model.
    always @(negedge clk) begin
        for (int k = 0; k < 3; k++) begin
            check($sformatf("out[%0d]", k),   dout[k],  (int'(din[k]) >= thr[k]));
            check($sformatf("out_q[%0d]", k), dq[k],    mq[k]);
            check($sformatf("rise[%0d]", k),  drise[k], mr[k]);
            check($sformatf("fall[%0d]", k),  dfall[k], mf[k]);
        end
    end

    task automatic set_in(input int k, input int v);
        @(negedge clk);
        #1;
        din[k] = 16'(v);
    endtask

    initial begin
        logic signed [15:0] r;
        rst_n  = 1'b0;
        din[0] = 16'sd0;
        din[1] = 16'sd0;
        din[2] = 16'sd0;

        // 1: combinational decision with no clock dependency
        for (int i = 0; i < 40; i++) begin
            #0.3;
            r = 16'($urandom_range(65535, 0));
            din[0] = r;
            #4ps;
            check("comb_rand", dout[0], (int'(r) >= 0));
        end

        // 2: boundaries
        din[0] = 16'sd0;    #4ps; check("bnd_zero", dout[0], 1'b1);
        din[0] = -16'sd1;   #4ps; check("bnd_m1",   dout[0], 1'b0);
        din[0] = Q15_ONE;   #4ps; check("bnd_max",  dout[0], 1'b1);
        din[0] = Q15_MINUS_ONE; #4ps; check("bnd_min", dout[0], 1'b0);

        // 3: held in reset, then release
        din[0] = 16'sd100;
        din[1] = 16'sd100;
        din[2] = 16'sd32767;
        #4ps;
        check("rst_out",   dout[0],  1'b1);
        check("rst_q",     dq[0],    1'b0);
        check("rst_rise",  drise[0], 1'b0);
        check("rst_fall",  dfall[0], 1'b0);
        repeat (3) @(negedge clk);
        check("rst_hold_q", dq[0], 1'b0);
        #1 rst_n = 1'b1;
        @(negedge clk);
        check("rel_q",    dq[0],    1'b1);
        check("rel_rise", drise[0], 1'b1);
        @(negedge clk);
        check("rel_rise_end", drise[0], 1'b0);
        check("rel_q_hold",   dq[0],    1'b1);

        // 6: unreachable upper band edge
        check("top_out",   dout[2], 1'b1);
        check("top_noset", dq[2],   1'b0);

        // 4: hysteresis walk on the HYST=64 instance
        check("hy_start", dq[1], 1'b1);
        set_in(1, -50); @(negedge clk); check("hy_m50_q", dq[1], 1'b1);
        set_in(1, -64); @(negedge clk); check("hy_m64_q", dq[1], 1'b1);
        set_in(1, -65); @(negedge clk);
        check("hy_m65_q", dq[1], 1'b0);
        check("hy_m65_fall", dfall[1], 1'b1);
        @(negedge clk); check("hy_fall_end", dfall[1], 1'b0);
        set_in(1, 63);  @(negedge clk); check("hy_63_q", dq[1], 1'b0);
        set_in(1, 64);  @(negedge clk);
        check("hy_64_q", dq[1], 1'b1);
        check("hy_64_rise", drise[1], 1'b1);
        @(negedge clk); check("hy_rise_end", drise[1], 1'b0);

        // 5: asynchronous mid-cycle reset
        @(posedge clk);
        #3;
        check("pre_arst_q", dq[0], 1'b1);
        rst_n = 1'b0;
        #4ps;
        check("arst_q0", dq[0], 1'b0);
        check("arst_q1", dq[1], 1'b0);
        check("arst_out", dout[0], 1'b1);
        @(negedge clk);
        #1 rst_n = 1'b1;

        // Free-running random traffic around the bands
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            #1;
            din[0] = 16'($urandom_range(65535, 0));
            din[1] = 16'(int'($urandom_range(300, 0)) - 150);
            din[2] = 16'(32767 - int'($urandom_range(30, 0)));
        end
        @(negedge clk);
        #1;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
